// File: rtl/enc_4x2_rr_if.sv
// Request/handshake bundle for the 4-to-2 round-robin encoder.
// master: request sources and downstream consumer; slave: the encoder.
interface enc_4x2_rr_if;
    logic [3:0] y_n;
    logic       en_n;
    logic       ready;
    logic       valid;
    logic       a;
    logic       b;

    modport master (
        output y_n,
        output en_n,
        output ready,
        input  valid,
        input  a,
        input  b
    );

    modport slave (
        input  y_n,
        input  en_n,
        input  ready,
        output valid,
        output a,
        output b
    );
endinterface

// File: rtl/enc_4x2_rr.sv
// Registered 4-to-2 round-robin encoder: captures active-low request pulses
// and presents each as a 2-bit code {a,b} under a valid/ready handshake.
module enc_4x2_rr (
    input logic         clk,
    input logic         rst_n,
    enc_4x2_rr_if.slave bus
);
    typedef enum logic {IDLE, HOLD} st_t;

    st_t        st, st_nxt;
    logic [3:0] pend, pend_nxt;
    logic [3:0] req, cand;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] idx, idx_nxt;
    logic [1:0] pick, j;
    logic       found;

    assign req  = bus.en_n ? 4'b0000 : ~bus.y_n;
    assign cand = pend | req;

    // First set bit of cand, searching from ptr upward with wrap.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            j = ptr + 2'(k);
            if (!found && cand[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        st_nxt   = st;
        pend_nxt = pend | req;
        ptr_nxt  = ptr;
        idx_nxt  = idx;
        case (st)
            IDLE: begin
                if (found) begin
                    idx_nxt = pick;
                    st_nxt  = HOLD;
                end
            end
            HOLD: begin
                // The accepted bit is cleared even if its line is still low now.
                if (bus.ready) begin
                    pend_nxt[idx] = 1'b0;
                    ptr_nxt       = idx + 2'd1;
                    st_nxt        = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            pend <= '0;
            ptr  <= '0;
            idx  <= '0;
        end else begin
            st   <= st_nxt;
            pend <= pend_nxt;
            ptr  <= ptr_nxt;
            idx  <= idx_nxt;
        end
    end

    assign bus.valid = (st == HOLD);
    assign bus.a     = idx[1];
    assign bus.b     = idx[0];
endmodule
